// File: rtl/raster_unpool_2x2.sv
// 2x2 unpooling stage: reassembles nibble pairs into 8-bit cells, buffers one
// reduced row, then replays it as two full-resolution rows (each cell doubled).
module raster_unpool_2x2 #(
  parameter int ROW_CELLS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_nib,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_cell,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eol
);

  localparam int COL_W = (ROW_CELLS > 1) ? $clog2(ROW_CELLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_CELLS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ph, w_ph_nxt;
  logic [3:0]       r_hi, w_hi_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             r_dup, w_dup_nxt;
  logic [7:0]       r_buf [ROW_CELLS];

  logic w_in_fire;
  logic w_out_fire;
  logic w_buf_we;
  logic w_last;

  // All outputs decode from registered state only, so reset clears them at once.
  assign w_last     = (r_col == LAST_COL);
  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state != LOAD);
  assign out_cell   = out_valid ? r_buf[r_col] : 8'h00;
  assign out_eol    = out_valid & w_last & r_dup;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_buf_we   = w_in_fire & r_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_ph    <= 1'b0;
      r_hi    <= 4'h0;
      r_col   <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      r_hi    <= w_hi_nxt;
      r_col   <= w_col_nxt;
      r_dup   <= w_dup_nxt;
    end
  end

  // Line buffer carries data only; LOAD masks it on out_cell, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_col] <= {r_hi, in_nib};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_hi_nxt    = r_hi;
    w_col_nxt   = r_col;
    w_dup_nxt   = r_dup;
    unique case (r_state)
      LOAD: begin
        if (w_in_fire) begin
          if (!r_ph) begin
            w_hi_nxt = in_nib;
            w_ph_nxt = 1'b1;
          end else begin
            w_ph_nxt = 1'b0;
            if (w_last) begin
              w_col_nxt   = '0;
              w_state_nxt = EMIT0;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end
        end
      end
      EMIT0, EMIT1: begin
        if (w_out_fire) begin
          if (!r_dup) begin
            w_dup_nxt = 1'b1;
          end else begin
            w_dup_nxt = 1'b0;
            if (w_last) begin
              w_col_nxt   = '0;
              w_state_nxt = (r_state == EMIT0) ? EMIT1 : LOAD;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_raster_unpool_2x2.sv
// Bench for raster_unpool_2x2: directed scenarios plus randomized bands,
// checked against a queue-based model of the expected unpooled stream.
`timescale 1ns/1ps
module tb_raster_unpool_2x2;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_nib = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_cell;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_eol;

  // Second instance exercising the single-cell row case.
  logic [3:0] s_in_nib = 4'h0;
  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [7:0] s_out_cell;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic       s_out_eol;

  int n_chk = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] cells [RC];

  raster_unpool_2x2 #(.ROW_CELLS(RC)) dut (
    .clk(clk), .rst_n(rst_n), .in_nib(in_nib), .in_valid(in_valid),
    .in_ready(in_ready), .out_cell(out_cell), .out_valid(out_valid),
    .out_ready(out_ready), .out_eol(out_eol)
  );

  raster_unpool_2x2 #(.ROW_CELLS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_nib(s_in_nib), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_cell(s_out_cell), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_eol(s_out_eol)
  );

  always #5 clk = ~clk;

  // Reference: two rows, each cell twice, end-of-row on the second copy of the last cell.
  task automatic build_exp();
    logic e;
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < RC; c++)
        for (int d = 0; d < 2; d++) begin
          e = (c == RC - 1) && (d == 1);
          exp_q.push_back({e, cells[c]});
        end
  endtask

  task automatic send_nib(input logic [3:0] n);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_nib   = n;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_nib_timeout: in_ready got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_row(input int gap, input bit rnd);
    int g;
    for (int c = 0; c < RC; c++) begin
      send_nib(cells[c][7:4]);
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      send_nib(cells[c][3:0]);
    end
  endtask

  // Collects handshaked outputs until the block returns to LOAD.
  task automatic drain(input int pct, output logic first_vld, output logic [7:0] first_cell,
                       output int busy);
    bit first;
    bit done;
    got_q.delete();
    busy = 0;
    first = 1'b1;
    done = 1'b0;
    first_vld = 1'b0;
    first_cell = 8'h00;
    out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (first) begin
        first_vld  = out_valid;
        first_cell = out_cell;
        first      = 1'b0;
      end
      if (in_ready) begin
        done = 1'b1;
      end else begin
        busy++;
        if (out_valid && out_ready) got_q.push_back({out_eol, out_cell});
        @(posedge clk);
        #1;
        out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: in_ready got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({in_ready, out_valid, out_eol, out_cell} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b eol=%b cell=%h required 1 0 0 00",
               in_ready, out_valid, out_eol, out_cell);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_band();
    logic fv;
    logic [7:0] fc;
    int busy;
    cells = '{8'h12, 8'h34, 8'h56, 8'h78};
    build_exp();
    out_ready = 1'b1;
    load_row(0, 1'b0);
    drain(100, fv, fc, busy);
    n_chk++;
    if (fv !== 1'b1 || fc !== 8'h12) begin
      n_fail++;
      $display("FAIL basic_latency: got vld=%b cell=%h required 1 12", fv, fc);
    end
    n_chk++;
    if (busy != 16) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d required 16", busy);
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_nibble_gaps();
    logic fv;
    logic [7:0] fc;
    int busy;
    cells = '{8'h12, 8'h34, 8'h56, 8'h78};
    build_exp();
    load_row(3, 1'b0);
    drain(100, fv, fc, busy);
    n_chk++;
    if (fv !== 1'b1 || fc !== 8'h12) begin
      n_fail++;
      $display("FAIL gaps_latency: got vld=%b cell=%h required 1 12", fv, fc);
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL gaps_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gaps_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] pre [3];
    int cnt;
    logic fv;
    logic [7:0] fc;
    int busy;
    cells = '{8'h12, 8'h34, 8'h56, 8'h78};
    build_exp();
    load_row(0, 1'b0);
    out_ready = 1'b1;
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 3; t++) begin
      @(negedge clk);
      if (out_valid) begin
        pre[cnt] = {out_eol, out_cell};
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_cell !== 8'h34 || out_eol !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got vld=%b cell=%h eol=%b required 1 34 0",
                 s, out_valid, out_cell, out_eol);
      end
      @(posedge clk);
      #1;
    end
    drain(100, fv, fc, busy);
    for (int i = cnt - 1; i >= 0; i--) got_q.push_front(pre[i]);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_input_blocked();
    logic fv;
    logic [7:0] fc;
    int busy;
    cells = '{8'h9C, 8'h3D, 8'hE4, 8'h07};
    build_exp();
    load_row(0, 1'b0);
    in_valid = 1'b1;
    in_nib   = 4'hF;
    drain(100, fv, fc, busy);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL blocked_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL blocked_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    // The held 0xF is taken on the return edge as the high nibble of cell 0.
    cells = '{8'hF1, 8'h22, 8'h33, 8'h44};
    build_exp();
    send_nib(4'h1);
    for (int c = 1; c < RC; c++) begin
      send_nib(cells[c][7:4]);
      send_nib(cells[c][3:0]);
    end
    drain(100, fv, fc, busy);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL blocked_reload_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL blocked_reload[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic fv;
    logic [7:0] fc;
    int busy;
    send_nib(4'h5);
    send_nib(4'h6);
    send_nib(4'h7);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, out_eol, out_cell} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_load_outputs: got rdy=%b vld=%b eol=%b cell=%h required 1 0 0 00",
               in_ready, out_valid, out_eol, out_cell);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cells = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    build_exp();
    load_row(0, 1'b0);
    drain(100, fv, fc, busy);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_load_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_load_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    logic fv;
    logic [7:0] fc;
    int busy;
    cells = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_row(0, 1'b0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_cell !== 8'h22) begin
      n_fail++;
      $display("FAIL emit1_position: got vld=%b cell=%h required 1 22", out_valid, out_cell);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, out_eol, out_cell} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_emit_outputs: got rdy=%b vld=%b eol=%b cell=%h required 1 0 0 00",
               in_ready, out_valid, out_eol, out_cell);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cells = '{8'h9A, 8'hB2, 8'h5C, 8'hD6};
    build_exp();
    load_row(0, 1'b0);
    drain(100, fv, fc, busy);
    n_chk++;
    if (fv !== 1'b1 || fc !== 8'h9A) begin
      n_fail++;
      $display("FAIL rst_emit_first: got vld=%b cell=%h required 1 9a", fv, fc);
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_emit_len: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_emit_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic fv;
    logic [7:0] fc;
    int busy;
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < RC; c++) cells[c] = 8'($urandom);
      build_exp();
      load_row(2, 1'b1);
      drain(60, fv, fc, busy);
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand_len[%0d]: got %0d required %0d", b, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_out[%0d][%0d]: got %h required %h", b, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_single_cell();
    logic [7:0] v;
    v = 8'h5E;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_nib    = v[7:4];
    @(posedge clk);
    #1;
    s_in_nib = v[3:0];
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (s_out_valid !== 1'b1 || s_out_cell !== v || s_out_eol !== ((i % 2) == 1)) begin
        n_fail++;
        $display("FAIL single_out[%0d]: got vld=%b cell=%h eol=%b required 1 %h %b",
                 i, s_out_valid, s_out_cell, s_out_eol, v, (i % 2) == 1);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_chk++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_return: got rdy=%b vld=%b required 1 0", s_in_ready, s_out_valid);
    end
    s_out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic_band();
    test_nibble_gaps();
    test_backpressure();
    test_input_blocked();
    test_reset_mid_load();
    test_reset_mid_emit();
    test_random();
    test_single_cell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_unpool_2x2.md
# raster_unpool_2x2

Inverse of the 2x2 focal-mean reduction stage in the Mini SPU raster path. It receives reduced cell values as nibble pairs (high nibble, then low nibble) on a 4-bit bus, reassembles each pair into an 8-bit cell, and buffers one reduced row. It then emits that row as two full-resolution output rows, with each cell replicated 2x horizontally and 2x vertically. It sits between the nibble-wide mean output path and any consumer that expects a full-resolution raster stream.

## Interface

- `ROW_CELLS`, default 4: reduced cells per input row (≥1); each output row is 2·ROW_CELLS cells.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_nib` input 4: nibble data; the high nibble of a cell is sent first, then the low nibble.
- `in_valid` input 1: `in_nib` is valid.
- `in_ready` output 1: the block accepts a nibble this cycle.
- `out_cell` output 8: full-resolution cell value.
- `out_valid` output 1: `out_cell` is valid.
- `out_ready` input 1: the consumer accepts `out_cell` this cycle.
- `out_eol` output 1: qualified by `out_valid`; marks the last cell of an output row.

## Operation

- **States:** LOAD, EMIT0, EMIT1.
- **Internal storage:**
  - Line buffer `buf[0..ROW_CELLS-1]`, 8 bits per entry.
  - Nibble phase bit `ph` (0 = expecting the high nibble).
  - 4-bit holding register `hi`.
  - Column index `col`, width clog2(ROW_CELLS), minimum 1 bit.
  - Duplicate bit `dup`.
- **LOAD:**
  - `in_ready`=1 and `out_valid`=0.
  - A nibble is accepted when `in_valid` & `in_ready`.
  - If `ph`=0, latch `hi` = `in_nib` and set `ph`=1.
  - If `ph`=1, write `buf[col]` = {`hi`, `in_nib`} and set `ph`=0.
  - If `col`=ROW_CELLS-1, clear `col` and go to EMIT0; otherwise increment `col`.
- **EMIT0 / EMIT1:**
  - `in_ready`=0, `out_valid`=1, `out_cell`=`buf[col]`.
  - `out_eol` = (`col`=ROW_CELLS-1) & (`dup`=1).
  - On `out_valid` & `out_ready`: if `dup`=0, set `dup`=1.
  - Otherwise set `dup`=0. If `col` is last, clear `col` and advance the state (EMIT0→EMIT1, EMIT1→LOAD); else increment `col`.
- **Output ordering:** each band produces 4·ROW_CELLS output cells: v0,v0,v1,v1,…,vN,vN, and then the same sequence again.
- **Stalls:** `out_cell` and `out_eol` hold stable while `out_valid`=1 and `out_ready`=0.
- **Input gaps:** gaps in `in_valid` between the nibbles of a pair are allowed; `ph` and `hi` persist across the gap.
- **No overlap:** input is never accepted during EMIT0/EMIT1. Upstream must hold its data until LOAD.
- **Buffer width:** no arithmetic on cell values; the buffer width exactly equals the nibble-pair width.

## Timing

- **Reset values:** state=LOAD, `ph`=0, `col`=0, `dup`=0, `hi`=0, `out_valid`=0, `in_ready`=1, `out_eol`=0, `out_cell`=0.
- **Reset:** the line buffer contents are not reset, but `out_cell` is forced to 0 while in LOAD.
- **Output derivation:** `in_ready`, `out_valid`, `out_cell` and `out_eol` are decoded from registered state and `buf` only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Latency:**
  - The low nibble of the last cell is accepted at edge k.
  - `out_valid`=1 starting in cycle k+1, showing `buf[0]`.
  - `in_ready`=0 from cycle k+1.
- **Throughput:**
  - With `out_ready` held high: one output per cycle, so a band takes 4·ROW_CELLS cycles.
  - After the final EMIT1 handshake at edge m, `in_ready`=1 and `out_valid`=0 in cycle m+1.
- **Load time:** 2·ROW_CELLS accepted nibbles per band, at a minimum of 2·ROW_CELLS cycles.
- **Asynchronous reset mid-operation:**
  - Any partial nibble pair, partial row, or in-progress emission is discarded.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
- **ROW_CELLS=1:** the band is v0,v0,v0,v0, and `out_eol` is high on the 2nd and 4th outputs.

## Test plan

- **Basic band:** ROW_CELLS=4, `out_ready`=1, nibbles 1,2,3,4,5,6,7,8 on consecutive cycles. Expect `out_cell` = 12,12,34,34,56,56,78,78 twice (hex), `out_eol` on the 8th and 16th outputs, `in_ready`=0 for exactly 16 cycles, then `in_ready`=1.
- **Nibble gaps:** the same data with `in_valid` low for 3 cycles between each high and low nibble. Expect an identical output sequence, and the first `out_valid` one cycle after the final low-nibble handshake.
- **Backpressure:** during EMIT0, drop `out_ready` for 5 cycles while the output is at the second copy of 0x34. Expect `out_cell`=0x34 and `out_valid`=1 held throughout, then the sequence resumes with 0x56, with no output lost or duplicated.
- **Input blocked during emit:** hold `in_valid`=1 with `in_nib`=0xF through EMIT0 and EMIT1. Expect no nibble consumed; after returning to LOAD, the first accepted nibble becomes the high nibble of cell 0.
- **Reset mid-load:** assert `rst_n`=0 after 3 nibbles, then release. Expect all outputs at their reset values. Reloading with A,B,C,D,E,F,0,1 must yield AB,AB,CD,CD,EF,EF,01,01 twice, with no residue from before the reset.
- **Reset mid-emit:** reset during EMIT1. Expect `out_valid` to drop asynchronously; after release, `in_ready`=1 and `ph`=0 (the next nibble is treated as a high nibble).
